// File: rtl/freq_synth_if.sv
// Memory-mapped register port of the frequency synthesiser.
// Reads are a combinational mux and have no strobe.
interface freq_synth_if;
   logic [1:0]  mm_address;
   logic        mm_write;
   logic [31:0] mm_writedata;
   logic [31:0] mm_readdata;

   modport master (output mm_address, output mm_write, output mm_writedata, input mm_readdata);
   modport slave  (input mm_address, input mm_write, input mm_writedata, output mm_readdata);
endinterface

// File: rtl/freq_synth.sv
// Programmable rate generator: Hz -> phase increment via restoring divider,
// then a 32-bit phase accumulator producing a square wave and a rising-edge tick.
//
//   state | meaning
//   IDLE  | increment stable, waiting for a FREQ write
//   DIV   | one quotient bit per cycle, cnt runs 31 down to 0
//   LOAD  | quotient complete, copied into the active increment
module freq_synth #(
   parameter int unsigned ReferenceClock = 50000000
) (
   input  logic         ref_clk,
   input  logic         reset,
   freq_synth_if.slave  mm,
   output logic         synth_out,
   output logic         tick
);

   localparam logic [32:0] REF_CLK  = 33'(ReferenceClock);
   localparam logic [31:0] FREQ_MAX = 32'(ReferenceClock / 2);

   typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

   state_t      state, state_next;
   logic [31:0] freq, inc, quo, acc;
   logic [32:0] rem, rem_shift;
   logic [4:0]  cnt;
   logic        enable, enable_next, busy;
   logic        freq_wr, ctrl_wr;
   logic [31:0] freq_clamped;

   always_comb begin
      freq_wr      = mm.mm_write && (mm.mm_address == 2'd0);
      ctrl_wr      = mm.mm_write && (mm.mm_address == 2'd3);
      freq_clamped = (mm.mm_writedata > FREQ_MAX) ? FREQ_MAX : mm.mm_writedata;
      enable_next  = ctrl_wr ? mm.mm_writedata[0] : enable;
      rem_shift    = rem << 1;
      busy         = (state != IDLE);
   end

   // A FREQ write restarts the division from any state; the stale quotient is dropped.
   always_comb begin
      state_next = state;
      if (freq_wr) begin
         state_next = DIV;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            DIV:     if (cnt == 5'd0) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge ref_clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         freq      <= '0;
         inc       <= '0;
         quo       <= '0;
         rem       <= '0;
         cnt       <= '0;
         enable    <= 1'b0;
         acc       <= '0;
         synth_out <= 1'b0;
         tick      <= 1'b0;
      end else begin
         enable <= enable_next;
         if (freq_wr) begin
            freq <= freq_clamped;
            rem  <= {1'b0, freq_clamped};
            quo  <= '0;
            cnt  <= 5'd31;
         end else if (state == DIV) begin
            cnt <= cnt - 5'd1;
            if (rem_shift >= REF_CLK) begin
               rem <= rem_shift - REF_CLK;
               quo <= {quo[30:0], 1'b1};
            end else begin
               rem <= rem_shift;
               quo <= {quo[30:0], 1'b0};
            end
         end else if (state == LOAD) begin
            inc <= quo;
         end
         // A disabling CTRL write clears the phase on the same edge, swallowing any wrap.
         acc       <= enable_next ? (acc + inc) : '0;
         synth_out <= acc[31];
         tick      <= acc[31] & ~synth_out;
      end
   end

   always_comb begin
      case (mm.mm_address)
         2'd0:    mm.mm_readdata = freq;
         2'd1:    mm.mm_readdata = {31'b0, busy};
         2'd2:    mm.mm_readdata = inc;
         default: mm.mm_readdata = {31'b0, enable};
      endcase
   end

endmodule

// File: doc/freq_synth.md
# freq_synth

Programmable frequency generator on the reference clock domain: software writes a target frequency in Hz over a simple memory-mapped port. The block computes the phase increment `floor(freq * 2^32 / ReferenceClock)` with an iterative divider, then drives a 32-bit phase accumulator. It outputs a square wave and a one-cycle tick at that rate. It serves as a known-rate test source for frequency measurement logic and as a rate strobe for downstream blocks.

## Interface
- `ReferenceClock`, 50000000, frequency of `ref_clk` in Hz; must be at most 2^31 - 1 and even.
- `ref_clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `mm_address`  in  2  register select.
- `mm_write`  in  1  write strobe; `mm_writedata` is sampled on the same edge.
- `mm_writedata`  in  32  write data.
- `mm_readdata`  out  32  combinational mux of the register at `mm_address`; zero-latency read, no read strobe.
- `synth_out`  out  1  square wave, registered copy of accumulator bit 31.
- `tick`  out  1  one-cycle pulse on each 0->1 transition of accumulator bit 31.

## Operation
- Register map (word address):
  - 0 FREQ: RW, requested Hz after clamping.
  - 1 STATUS: RO, bit0 = busy, other bits 0.
  - 2 INC: RO, active phase increment.
  - 3 CTRL: RW, bit0 = enable, other bits read 0.
- Write to FREQ:
  - Store `min(writedata, ReferenceClock/2)`.
  - Load the divider remainder (33 bits) with the stored value and clear the quotient.
  - Set busy and start the division.
- Divider: restoring division, one quotient bit per cycle, 32 iterations.
  - Each step: `rem = rem << 1`. If `rem >= ReferenceClock`, then `rem -= ReferenceClock` and the quotient bit is 1.
  - The quotient fits 32 bits because FREQ < ReferenceClock.
- FSM states:
  - IDLE -> DIV on a FREQ write.
  - DIV counts 0..31, then goes to LOAD.
  - LOAD writes the quotient to INC, clears busy, returns to IDLE.
- FREQ write while in DIV or LOAD aborts the current division. It restarts from iteration 0 with the new value; the old quotient is never loaded.
- FREQ = 0 yields INC = 0. The accumulator holds its value, so `synth_out` is frozen and no ticks occur.
- Accumulator:
  - enable=1: `acc <= acc + INC` each cycle, modulo 2^32.
  - enable=0: `acc <= 0`.
  - An INC change does not reset `acc`, so the output stays phase-continuous.
- Writes to STATUS or INC are ignored. CTRL writes take effect on the next edge.

## Timing
- Reset values: FREQ=0, INC=0, CTRL=0, busy=0, acc=0, FSM=IDLE, `synth_out`=0, `tick`=0. `mm_readdata` reflects these immediately after reset.
- Reset mid-division: the division is abandoned, INC stays 0 and busy=0.
- FREQ write on edge N:
  - FREQ reads the new value from N+1; busy=1 from N+1.
  - INC updates and busy=0 at edge N+33, so the latency is 33 cycles.
- Accumulator latency:
  - New INC is first added on edge N+34.
  - `synth_out` and `tick` lag accumulator bit 31 by one cycle.
- `tick` is high for exactly one cycle per accumulator period and never two cycles in a row. Exception: INC = 0x80000000 gives a tick every 2 cycles.
- Simultaneous FREQ write and reset: reset wins.
- Simultaneous CTRL write with enable=0 and accumulator wrap: the accumulator clears and no tick is produced for that wrap.

## Test plan
- Reset, then read all four addresses -> 0, 0, 0, 0; `synth_out`=0, `tick`=0 for 100 cycles.
- Write FREQ=12500000, poll busy until it clears -> busy high for exactly 32 reads after the write edge, INC=0x40000000. Enable -> `tick` every 4 cycles, `synth_out` 2 high / 2 low.
- Write FREQ=1000000, enable, count ticks over 50000 cycles -> INC=0x051EB851, ticks 999..1000.
- Write FREQ=30000000 -> FREQ reads 25000000, INC=0x80000000, `synth_out` toggles every cycle. Write FREQ=1 -> INC=0x00000055.
- Write FREQ=1000000, then write FREQ=12500000 10 cycles later -> INC is never 0x051EB851, becomes 0x40000000 33 cycles after the second write, busy stays high throughout.
- Running at 12.5 MHz, write CTRL=0 -> `synth_out` low and no ticks within 2 cycles. Assert reset during a division -> INC=0, busy=0, FREQ=0.
